// File: rtl/mem_responder.sv
// Unified instruction/data memory responder for the multi-cycle CPU.
// Requests are captured, held for WAIT_CYCLES wait states, completed, and acknowledged with a MemReady pulse.
module mem_responder #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [31:0]       Address,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] MemData,
    output logic              MemReady,
    output logic              Busy,
    output logic              AddrErr
);

    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                wr_q, wr_d;
    logic                err_q, err_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   mem_data_q, mem_data_d;
    logic                mem_ready_q, mem_ready_d;
    logic                busy_q, busy_d;
    logic                addr_err_q, addr_err_d;

    logic                req;
    logic                bad_req;
    logic                mem_we;

    logic [DATA_W-1:0]   mem_q [2**ADDR_W];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        err_d       = err_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        mem_data_d  = mem_data_q;
        mem_ready_d = 1'b0;
        busy_d      = busy_q;
        addr_err_d  = addr_err_q;

        req     = MemRead | MemWrite;
        bad_req = (Address[1:0] != 2'b00)
               || ((Address >> (ADDR_W + 2)) != 32'd0)
               || (MemRead && MemWrite);

        case (state_q)
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d     = S_DONE;
                    mem_ready_d = 1'b1;
                    if (err_q) begin
                        addr_err_d = 1'b1;
                    end else if (!wr_q) begin
                        mem_data_d = mem_q[idx_q];
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: ;
        endcase

        // The edge that ends the DONE cycle also samples requests, giving back-to-back spacing of WAIT_CYCLES+2.
        if (req && (state_q != S_WAIT)) begin
            state_d = S_WAIT;
            busy_d  = 1'b1;
            cnt_d   = CNT_LOAD;
            wr_d    = MemWrite;
            err_d   = bad_req;
            idx_d   = Address[ADDR_W+1:2];
            wdata_d = WriteData;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            err_q       <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= '0;
            mem_data_q  <= '0;
            mem_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            addr_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            err_q       <= err_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            mem_data_q  <= mem_data_d;
            mem_ready_q <= mem_ready_d;
            busy_q      <= busy_d;
            addr_err_q  <= addr_err_d;
        end
    end

    // Array is not reset; a reset mid-access drops state_q to IDLE so the pending write never fires.
    assign mem_we = (state_q == S_WAIT) && (cnt_q == '0) && wr_q && !err_q;

    always_ff @(posedge Clk) begin
        if (mem_we) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign MemData  = mem_data_q;
    assign MemReady = mem_ready_q;
    assign Busy     = busy_q;
    assign AddrErr  = addr_err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance share stimulus.
module tb_mem_responder;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        MemRead, MemWrite;
    logic [31:0] Address, WriteData;
    logic [31:0] MemData;
    logic        MemReady, Busy, AddrErr;
    logic [31:0] z_data;
    logic        z_ready, z_busy, z_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 Clk = ~Clk;

    mem_responder #(.DATA_W(32), .ADDR_W(8), .WAIT_CYCLES(2)) dut (
        .Clk(Clk), .Reset(Reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .Address(Address), .WriteData(WriteData), .MemData(MemData),
        .MemReady(MemReady), .Busy(Busy), .AddrErr(AddrErr)
    );

    mem_responder #(.DATA_W(32), .ADDR_W(8), .WAIT_CYCLES(0)) dut_z (
        .Clk(Clk), .Reset(Reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .Address(Address), .WriteData(WriteData), .MemData(z_data),
        .MemReady(z_ready), .Busy(z_busy), .AddrErr(z_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge; returns one cycle after the MemReady sample.
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] data, output int lat, output int busy_cnt,
                             output logic [31:0] rdata);
        MemRead = rd; MemWrite = wr; Address = addr; WriteData = data;
        @(posedge Clk); #1;
        MemRead = 1'b0; MemWrite = 1'b0; Address = 32'hFFFF_FFFF; WriteData = 32'h0;
        lat = 0;
        rdata = 32'hDEAD_0BAD;
        busy_cnt = Busy ? 1 : 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge Clk); #1;
            if (Busy) busy_cnt++;
            if (MemReady) begin
                lat = n;
                rdata = MemData;
                break;
            end
        end
        @(posedge Clk); #1;
        if (Busy) busy_cnt++;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1);
    end

    initial begin
        int lat, bc, last, pulses;
        logic prev;
        logic [31:0] rd;

        Reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; Address = 32'h0; WriteData = 32'h0;
        #3;
        check("rst_data",  MemData, 0);
        check("rst_ready", MemReady, 0);
        check("rst_busy",  Busy, 0);
        check("rst_err",   AddrErr, 0);
        @(posedge Clk); #1;
        Reset = 1'b0;
        @(posedge Clk); #1;

        // 1: write latency and busy width
        do_access(1'b0, 1'b1, 32'h10, 32'h1234_5678, lat, bc, rd);
        check("t1_lat", lat, 3);
        check("t1_busy_cycles", bc, 4);
        check("t1_ready_after", MemReady, 0);
        check("t1_busy_after", Busy, 0);

        // 2: read back, data held afterwards
        do_access(1'b1, 1'b0, 32'h10, 32'h0, lat, bc, rd);
        check("t2_lat", lat, 3);
        check("t2_data_ready", rd, 32'h1234_5678);
        repeat (3) @(posedge Clk);
        #1;
        check("t2_data_held", MemData, 32'h1234_5678);

        // 3: level-held read, captures every 4 cycles
        do_access(1'b0, 1'b1, 32'h0, 32'h0BAD_F00D, lat, bc, rd);
        MemRead = 1'b1; Address = 32'h0;
        last = 0; pulses = 0; prev = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge Clk); #1;
            if (MemReady) begin
                pulses++;
                check("t3_width", prev, 0);
                check("t3_spacing", k - last, 4);
                check("t3_data", MemData, 32'h0BAD_F00D);
                last = k;
            end
            prev = MemReady;
        end
        MemRead = 1'b0;
        check("t3_pulses", pulses, 5);

        // 4: misaligned read
        do_access(1'b1, 1'b0, 32'h13, 32'h0, lat, bc, rd);
        check("t4_lat", lat, 3);
        check("t4_data_kept", rd, 32'h0BAD_F00D);
        check("t4_err", AddrErr, 1);
        do_access(1'b1, 1'b0, 32'h10, 32'h0, lat, bc, rd);
        check("t4_good_data", rd, 32'h1234_5678);
        check("t4_err_sticky", AddrErr, 1);

        // 5: read and write together
        do_access(1'b0, 1'b1, 32'h20, 32'hAAAA_AAAA, lat, bc, rd);
        do_access(1'b1, 1'b1, 32'h20, 32'h5555_5555, lat, bc, rd);
        check("t5_lat", lat, 3);
        check("t5_data_kept", rd, 32'h1234_5678);
        check("t5_err", AddrErr, 1);
        do_access(1'b1, 1'b0, 32'h20, 32'h0, lat, bc, rd);
        check("t5_readback", rd, 32'hAAAA_AAAA);

        // 6: reset one cycle after a write capture
        do_access(1'b0, 1'b1, 32'h30, 32'hCAFE_0030, lat, bc, rd);
        MemWrite = 1'b1; Address = 32'h30; WriteData = 32'hDEAD_BEEF;
        @(posedge Clk); #1;
        MemWrite = 1'b0;
        @(posedge Clk); #1;
        Reset = 1'b1;
        #1;
        check("t6_rst_data",  MemData, 0);
        check("t6_rst_busy",  Busy, 0);
        check("t6_rst_ready", MemReady, 0);
        check("t6_rst_err",   AddrErr, 0);
        check("t6_rst_zdata", z_data, 0);
        check("t6_rst_zerr",  z_err, 0);
        #3;
        Reset = 1'b0;
        @(posedge Clk); #1;
        do_access(1'b1, 1'b0, 32'h30, 32'h0, lat, bc, rd);
        check("t6_old_data", rd, 32'hCAFE_0030);
        check("t6_z_completed", z_data, 32'hDEAD_BEEF);

        // 6b: WAIT_CYCLES=0 latency
        MemWrite = 1'b1; Address = 32'h40; WriteData = 32'h0000_0040;
        @(posedge Clk); #1;
        MemWrite = 1'b0;
        check("z_busy_capture", z_busy, 1);
        check("z_ready_capture", z_ready, 0);
        @(posedge Clk); #1;
        check("z_ready_pulse", z_ready, 1);
        @(posedge Clk); #1;
        check("z_ready_end", z_ready, 0);
        check("z_busy_end", z_busy, 0);
        repeat (3) @(posedge Clk);
        #1;

        // 6c: WAIT_CYCLES=0 reset right after capture
        MemWrite = 1'b1; Address = 32'h30; WriteData = 32'h5555_0000;
        @(posedge Clk); #1;
        MemWrite = 1'b0;
        Reset = 1'b1;
        #1;
        check("z_abort_busy", z_busy, 0);
        check("z_abort_ready", z_ready, 0);
        #3;
        Reset = 1'b0;
        @(posedge Clk); #1;
        do_access(1'b1, 1'b0, 32'h30, 32'h0, lat, bc, rd);
        check("t6c_data", rd, 32'hCAFE_0030);
        check("t6c_zdata", z_data, 32'hDEAD_BEEF);

        // out-of-range address
        check("oor_err_before", AddrErr, 0);
        do_access(1'b1, 1'b0, 32'h0000_0400, 32'h0, lat, bc, rd);
        check("oor_lat", lat, 3);
        check("oor_data_kept", rd, 32'hCAFE_0030);
        check("oor_err", AddrErr, 1);
        check("oor_zerr", z_err, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
